// File: rtl/cache_fill_fsm_if.sv
// Cache-fill bundle: miss request, memory request/response and
// data/tag array write strobes between the L1 cache and main memory.
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int OW = $clog2(BLOCK_WORDS);

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  memory_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  write_data_array;
  logic [OW-1:0]         data_word_offset;
  logic [15:0]           data_out;
  logic                  write_tag_array;

  modport master (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  memory_enable,
    input  memory_address,
    input  write_data_array,
    input  data_word_offset,
    input  data_out,
    input  write_tag_array
  );

  modport slave (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output memory_enable,
    output memory_address,
    output write_data_array,
    output data_word_offset,
    output data_out,
    output write_tag_array
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: issues one read per word of the missing block,
// steers returning words into the data array, writes the tag on the last.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cache_fill_fsm_if.slave bus
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int CW = OW + 1;

  localparam logic [CW-1:0] FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         req_q, req_d;
  logic [CW-1:0]         rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic in_fill;
  logic req_open;
  logic rsp_ok;
  logic last_rsp;

  assign in_fill  = (state_q == FILL);
  assign req_open = in_fill && (req_q < FULL);
  // a response with nothing outstanding is dropped
  assign rsp_ok   = in_fill && bus.memory_data_valid
                 && (rsp_q < req_q);
  assign last_rsp = rsp_ok && (rsp_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d = FILL;
          base_d  = bus.miss_address & BASE_MASK;
          req_d   = '0;
          rsp_d   = '0;
        end
      end
      FILL: begin
        if (req_open) req_d = req_q + 1'b1;
        if (rsp_ok)   rsp_d = rsp_q + 1'b1;
        if (last_rsp) begin
          state_d = IDLE;
          req_d   = '0;
          rsp_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fsm_busy         = in_fill;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.data_word_offset = '0;
    bus.data_out         = '0;
    bus.write_tag_array  = 1'b0;
    if (req_open) begin
      bus.memory_enable  = 1'b1;
      bus.memory_address = base_q
                         + ADDR_WIDTH'({req_q, 1'b0});
    end
    if (rsp_ok) begin
      bus.write_data_array = 1'b1;
      bus.data_word_offset = rsp_q[OW-1:0];
      bus.data_out         = bus.memory_data;
    end
    bus.write_tag_array = last_rsp;
  end

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_fill && bus.memory_data_valid
      && (rsp_q >= req_q))
  ) else $error("cache_fill_fsm: response with no outstanding request");

endmodule
